// File: rtl/vend_pkg.sv
// Shared vending definitions: state encoding, product codes, change limits.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MOTOR,
    WAIT_DROP,
    COIN_HI,
    COIN_LO,
    FIN,
    FAULT
  } vend_state_t;

  localparam logic [1:0] PROD_NONE  = 2'b00;
  localparam logic [1:0] PROD_CHOC  = 2'b01;
  localparam logic [1:0] PROD_DRINK = 2'b10;

  localparam int CHANGE_W = 3;
  localparam logic [CHANGE_W-1:0] CHANGE_MAX = 3'd4;

  // Hopper holds at most CHANGE_MAX coins per vend; larger requests saturate.
  function automatic logic [CHANGE_W-1:0] clamp_change(input logic [CHANGE_W-1:0] c);
    return (c > CHANGE_MAX) ? CHANGE_MAX : c;
  endfunction

  function automatic logic prod_valid(input logic [1:0] p);
    return (p == PROD_CHOC) || (p == PROD_DRINK);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vend_pulse_timer.sv
// Loadable down-counter; o_expire marks the last cycle of the loaded interval.
module vend_pulse_timer #(
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expire = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense stage: runs one product motor, confirms the drop, then pays out change.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int MOTOR_CYCLES = 8,
  parameter int DROP_TIMEOUT = 32,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_done,
  input  logic [1:0] i_product,
  input  logic [2:0] i_change,
  input  logic       i_drop_sense,
  output logic       o_motor_choc,
  output logic       o_motor_drink,
  output logic       o_coin_out,
  output logic       o_busy,
  output logic       o_vend_complete,
  output logic       o_overrun,
  output logic       o_fault
);

  localparam int TMR_MAX = max_int(max_int(MOTOR_CYCLES, DROP_TIMEOUT),
                                   max_int(PULSE_CYCLES, GAP_CYCLES));
  localparam int CNT_W   = $clog2(TMR_MAX + 1);

  vend_state_t         r_state;
  vend_state_t         w_state_nxt;
  logic [1:0]          r_product;
  logic [CHANGE_W-1:0] r_change;
  logic                r_drop_seen;
  logic                r_overrun;
  logic                w_expire;
  logic                w_load;
  logic [CNT_W-1:0]    w_load_val;

  // One timer serves every timed state; it is reloaded whenever the state changes.
  assign w_load = (w_state_nxt != r_state);

  // Interval length for the state being entered.
  always_comb begin
    w_load_val = '0;
    case (w_state_nxt)
      MOTOR:     w_load_val = CNT_W'(MOTOR_CYCLES);
      WAIT_DROP: w_load_val = CNT_W'(DROP_TIMEOUT);
      COIN_HI:   w_load_val = CNT_W'(PULSE_CYCLES);
      COIN_LO:   w_load_val = CNT_W'(GAP_CYCLES);
      default:   w_load_val = '0;
    endcase
  end

  vend_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_expire   (w_expire)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a drop detected in WAIT_DROP wins over a same-cycle timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_done) begin
          if (prod_valid(i_product)) begin
            w_state_nxt = MOTOR;
          end else if (clamp_change(i_change) != '0) begin
            w_state_nxt = COIN_HI;
          end else begin
            w_state_nxt = FIN;
          end
        end
      end
      MOTOR: begin
        if (w_expire) begin
          w_state_nxt = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        if (r_drop_seen || i_drop_sense) begin
          w_state_nxt = (r_change != '0) ? COIN_HI : FIN;
        end else if (w_expire) begin
          w_state_nxt = FAULT;
        end
      end
      COIN_HI: begin
        if (w_expire) begin
          // r_change still holds the count including the coin just ejected.
          w_state_nxt = (r_change > CHANGE_W'(1)) ? COIN_LO : FIN;
        end
      end
      COIN_LO: begin
        if (w_expire) begin
          w_state_nxt = COIN_HI;
        end
      end
      FIN:     w_state_nxt = IDLE;
      FAULT:   w_state_nxt = FAULT;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Transaction capture, drop latch, remaining-change count and overrun strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_product   <= PROD_NONE;
      r_change    <= '0;
      r_drop_seen <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= i_done && (r_state != IDLE);
      if ((r_state == IDLE) && i_done) begin
        r_product   <= i_product;
        r_change    <= clamp_change(i_change);
        r_drop_seen <= 1'b0;
      end else begin
        if ((r_state == MOTOR) && i_drop_sense) begin
          r_drop_seen <= 1'b1;
        end
        if ((r_state == COIN_HI) && w_expire) begin
          r_change <= r_change - CHANGE_W'(1);
        end
      end
    end
  end

  // Output decode from registered state only; motors and hopper are mutually exclusive by state.
  always_comb begin
    o_motor_choc    = 1'b0;
    o_motor_drink   = 1'b0;
    o_coin_out      = 1'b0;
    o_vend_complete = 1'b0;
    o_fault         = 1'b0;
    o_busy          = (r_state != IDLE);
    o_overrun       = r_overrun;
    case (r_state)
      MOTOR: begin
        o_motor_choc  = (r_product == PROD_CHOC);
        o_motor_drink = (r_product == PROD_DRINK);
      end
      COIN_HI: o_coin_out      = 1'b1;
      FIN:     o_vend_complete = 1'b1;
      FAULT:   o_fault         = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: transaction-timeline model plus directed and random stimulus.
module tb_vend_dispense_ctrl;

  logic       clk = 1'b0;
  logic       rst, done, drop;
  logic [1:0] prod;
  logic [2:0] chg;
  logic       mc, md, coin, busy, vc, ovr, fault;

  always #5 clk = ~clk;

  vend_dispense_ctrl dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_done          (done),
    .i_product       (prod),
    .i_change        (chg),
    .i_drop_sense    (drop),
    .o_motor_choc    (mc),
    .o_motor_drink   (md),
    .o_coin_out      (coin),
    .o_busy          (busy),
    .o_vend_complete (vc),
    .o_overrun       (ovr),
    .o_fault         (fault)
  );

  int checks   = 0;
  int failures = 0;

  // Model: a transaction becomes a queue of per-cycle output slots.
  localparam int E_MC = 1, E_MD = 2, E_COIN = 4, E_FIN = 8, E_WAIT = 16;
  int unsigned q[$];
  bit m_fault = 0, m_ovr = 0, m_drop = 0;
  int m_wait  = 0;

  // Observation tallies for hand-computed expectations.
  int rel = 0, c_mc = 0, c_md = 0, c_coin_hi = 0, c_coin_rise = 0, c_vc = 0, c_ovr = 0, vc_at = -1;
  bit prev_coin = 0;
  int stepno = 0;

  function automatic logic [6:0] model_out();
    logic [6:0] r;
    int unsigned h;
    r = '0;
    if (q.size() > 0) begin
      h = q[0];
      r[6] = (h & E_MC)   != 0;
      r[5] = (h & E_MD)   != 0;
      r[4] = (h & E_COIN) != 0;
      r[3] = (h & E_FIN)  != 0;
    end
    r[2] = (q.size() > 0) || m_fault;
    r[1] = m_ovr;
    r[0] = m_fault;
    return r;
  endfunction

  task automatic build(input logic [1:0] p, input logic [2:0] c);
    int n;
    n = (c > 4) ? 4 : int'(c);
    m_drop = 0;
    m_wait = 0;
    if (p == 2'b01 || p == 2'b10) begin
      repeat (8) q.push_back((p == 2'b01) ? E_MC : E_MD);
      q.push_back(E_WAIT);
    end
    for (int i = 0; i < n; i++) begin
      repeat (2) q.push_back(E_COIN);
      if (i < n - 1) repeat (2) q.push_back(0);
    end
    q.push_back(E_FIN);
  endtask

  task automatic model_step(input bit r, input bit d, input logic [1:0] p,
                            input logic [2:0] c, input bit ds);
    bit busy_now;
    if (r) begin
      q.delete();
      m_fault = 0; m_ovr = 0; m_drop = 0; m_wait = 0;
      return;
    end
    busy_now = (q.size() > 0) || m_fault;
    m_ovr = d && busy_now;
    if (!busy_now) begin
      if (d) build(p, c);
    end else if (!m_fault) begin
      if (q[0] == E_WAIT) begin
        if (m_drop || ds) begin
          void'(q.pop_front());
        end else begin
          m_wait++;
          if (m_wait == 32) begin
            m_fault = 1;
            q.delete();
          end
        end
      end else begin
        if (((q[0] & (E_MC | E_MD)) != 0) && ds) m_drop = 1;
        void'(q.pop_front());
      end
    end
  endtask

  // Compare at the falling edge, then drive the inputs for the next rising edge.
  task automatic step(input bit r, input bit d, input logic [1:0] p,
                      input logic [2:0] c, input bit ds);
    logic [6:0] exp_v, act_v;
    @(negedge clk);
    exp_v = model_out();
    act_v = {mc, md, coin, vc, busy, ovr, fault};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL outputs step=%0d {mc,md,coin,vc,busy,ovr,fault} act=%b exp=%b",
               stepno, act_v, exp_v);
    end
    if (mc) c_mc++;
    if (md) c_md++;
    if (coin) c_coin_hi++;
    if (coin && !prev_coin) c_coin_rise++;
    if (vc) begin c_vc++; vc_at = rel; end
    if (ovr) c_ovr++;
    prev_coin = coin;
    rst = r; done = d; prod = p; chg = c; drop = ds;
    model_step(r, d, p, c, ds);
    rel++;
    stepno++;
  endtask

  task automatic idle(input int k_from, input int k_to, input int drop_k);
    for (int k = k_from; k <= k_to; k++) step(0, 0, 2'b00, 3'd0, k == drop_k);
  endtask

  task automatic clr();
    rel = 0; c_mc = 0; c_md = 0; c_coin_hi = 0; c_coin_rise = 0; c_vc = 0; c_ovr = 0; vc_at = -1;
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp_v);
    end
  endtask

  initial begin
    rst = 1; done = 0; prod = 0; chg = 0; drop = 0;
    step(1, 0, 2'b00, 3'd0, 0);
    step(0, 0, 2'b00, 3'd0, 0);
    chk("reset_outputs", int'({mc, md, coin, vc, busy, ovr, fault}), 0);
    idle(1, 2, -1);

    // Chocolate, no change, drop in 5th motor cycle.
    clr();
    step(0, 1, 2'b01, 3'd0, 0);
    idle(1, 20, 5);
    chk("s1_motor_choc_cycles", c_mc, 8);
    chk("s1_coin_pulses", c_coin_rise, 0);
    chk("s1_vend_complete_count", c_vc, 1);
    chk("s1_vend_complete_cycle", vc_at, 10);
    chk("s1_busy_after", int'(busy), 0);

    // Drink, 3 coins, drop during first WAIT_DROP cycle.
    clr();
    step(0, 1, 2'b10, 3'd3, 0);
    idle(1, 25, 9);
    chk("s2_motor_drink_cycles", c_md, 8);
    chk("s2_coin_pulses", c_coin_rise, 3);
    chk("s2_coin_high_cycles", c_coin_hi, 6);
    chk("s2_vend_complete_cycle", vc_at, 20);
    chk("s2_vend_complete_count", c_vc, 1);

    // Chocolate, 2 coins owed, drop never seen -> fault.
    clr();
    step(0, 1, 2'b01, 3'd2, 0);
    idle(1, 40, -1);
    chk("s3_fault_before_timeout", int'(fault), 0);
    idle(41, 45, -1);
    chk("s3_fault_set", int'(fault), 1);
    chk("s3_no_coins", c_coin_rise, 0);
    chk("s3_no_complete", c_vc, 0);
    clr();
    step(0, 1, 2'b01, 3'd1, 0);
    idle(1, 4, -1);
    chk("s3_fault_sticky", int'(fault), 1);
    chk("s3_overrun_in_fault", c_ovr, 1);
    chk("s3_no_motor_in_fault", c_mc, 0);
    step(1, 0, 2'b00, 3'd0, 0);
    step(0, 0, 2'b00, 3'd0, 0);
    chk("s3_fault_cleared", int'(fault), 0);

    // No product, change 7 clamps to 4 coins.
    clr();
    step(0, 1, 2'b00, 3'd7, 0);
    idle(1, 20, -1);
    chk("s4_coin_pulses", c_coin_rise, 4);
    chk("s4_motor_cycles", c_mc + c_md, 0);
    chk("s4_vend_complete_cycle", vc_at, 15);

    // Second done during MOTOR.
    clr();
    step(0, 1, 2'b01, 3'd1, 0);
    step(0, 0, 2'b00, 3'd0, 0);
    step(0, 0, 2'b00, 3'd0, 0);
    step(0, 0, 2'b00, 3'd0, 1);
    step(0, 1, 2'b10, 3'd4, 0);
    idle(5, 25, -1);
    chk("s5_overrun_pulses", c_ovr, 1);
    chk("s5_motor_choc_cycles", c_mc, 8);
    chk("s5_motor_drink_cycles", c_md, 0);
    chk("s5_coin_pulses", c_coin_rise, 1);
    chk("s5_vend_complete_count", c_vc, 1);

    // Reset during the 2nd coin pulse, then immediate new transaction.
    clr();
    step(0, 1, 2'b00, 3'd3, 0);
    idle(1, 4, -1);
    step(1, 0, 2'b00, 3'd0, 0);
    chk("s6_coin_before_rst", c_coin_rise, 2);
    clr();
    step(0, 1, 2'b10, 3'd0, 0);
    chk("s6_busy_after_rst", int'(busy), 0);
    chk("s6_coin_after_rst", int'(coin), 0);
    idle(1, 15, 2);
    chk("s6_motor_drink_cycles", c_md, 8);
    chk("s6_vend_complete_cycle", vc_at, 10);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 5) == 0,
           2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           $urandom_range(0, 9) == 0);
    end
    step(0, 0, 2'b00, 3'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
